// File: rtl/cache_refill_arbiter.sv
// Refill arbiter: grants one of two cache misses, optionally writes back the dirty
// victim line, then reads the replacement line as one 32-bit burst and pulses refresh.
module cache_refill_arbiter #(
  parameter int CACHELINE_WD = 512
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_icache_miss,
  input  logic [31:0]             i_icache_raddr,
  output logic                    o_icache_refresh,
  output logic [CACHELINE_WD-1:0] o_icache_cacheline_new,
  input  logic                    i_dcache_miss,
  input  logic [31:0]             i_dcache_raddr,
  input  logic                    i_dcache_write_back,
  input  logic [31:0]             i_dcache_waddr,
  input  logic [CACHELINE_WD-1:0] i_dcache_cacheline_old,
  output logic                    o_dcache_refresh,
  output logic [CACHELINE_WD-1:0] o_dcache_cacheline_new,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [31:0]             o_araddr,
  output logic [7:0]              o_arlen,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [31:0]             i_rdata,
  input  logic                    i_rlast,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [31:0]             o_awaddr,
  output logic [7:0]              o_awlen,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [31:0]             o_wdata,
  output logic                    o_wlast,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic [2:0]              o_state
);

  localparam int BEATS  = CACHELINE_WD / 32;
  localparam int OFS_WD = $clog2(CACHELINE_WD / 8);
  localparam int CNT_WD = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_WD-1:0] LAST_BEAT = CNT_WD'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_AW   = 3'd1,
    WB_W    = 3'd2,
    WB_B    = 3'd3,
    RD_AR   = 3'd4,
    RD_R    = 3'd5,
    REFRESH = 3'd6,
    COOL    = 3'd7
  } state_t;

  state_t                  r_state;
  logic                    r_is_d;
  logic [31-OFS_WD:0]      r_raddr;
  logic [31-OFS_WD:0]      r_waddr;
  logic [CACHELINE_WD-1:0] r_wb_line;
  logic [CACHELINE_WD-1:0] r_buf;
  logic [CNT_WD-1:0]       r_cnt;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_wlast;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_irefresh;
  logic                    r_drefresh;
  logic                    w_unused;

  // Handshakes: a transfer happens on a rising edge where valid && ready; a raised
  // valid stays high with stable payload until that edge, ready never waits on valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_is_d     <= 1'b0;
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_wb_line  <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_wlast    <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_irefresh <= 1'b0;
      r_drefresh <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_dcache_miss) begin
            r_is_d    <= 1'b1;
            r_raddr   <= i_dcache_raddr[31:OFS_WD];
            r_waddr   <= i_dcache_waddr[31:OFS_WD];
            r_wb_line <= i_dcache_cacheline_old;
            if (i_dcache_write_back) begin
              r_awvalid <= 1'b1;
              r_state   <= WB_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_AR;
            end
          end else if (i_icache_miss) begin
            r_is_d    <= 1'b0;
            r_raddr   <= i_icache_raddr[31:OFS_WD];
            r_arvalid <= 1'b1;
            r_state   <= RD_AR;
          end
        end
        WB_AW: begin
          if (i_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (BEATS == 1);
            r_cnt     <= '0;
            r_state   <= WB_W;
          end
        end
        WB_W: begin
          // The victim line shifts down one word per accepted beat; wdata is its low word.
          if (i_wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= WB_B;
            end else begin
              r_wb_line <= r_wb_line >> 32;
              r_cnt     <= r_cnt + 1'b1;
              r_wlast   <= (r_cnt == CNT_WD'(BEATS - 2));
            end
          end
        end
        WB_B: begin
          if (i_bvalid) begin
            r_bready  <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= RD_AR;
          end
        end
        RD_AR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= RD_R;
          end
        end
        RD_R: begin
          // An early rlast leaves the untouched words of the buffer as they were.
          if (i_rvalid) begin
            r_buf[{r_cnt, 5'd0} +: 32] <= i_rdata;
            r_cnt <= r_cnt + 1'b1;
            if (i_rlast || (r_cnt == LAST_BEAT)) begin
              r_rready   <= 1'b0;
              r_irefresh <= !r_is_d;
              r_drefresh <= r_is_d;
              r_state    <= REFRESH;
            end
          end
        end
        REFRESH: begin
          r_irefresh <= 1'b0;
          r_drefresh <= 1'b0;
          r_state    <= COOL;
        end
        COOL:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_icache_refresh       = r_irefresh;
  assign o_dcache_refresh       = r_drefresh;
  assign o_icache_cacheline_new = r_buf;
  assign o_dcache_cacheline_new = r_buf;
  assign o_arvalid              = r_arvalid;
  assign o_araddr               = {r_raddr, {OFS_WD{1'b0}}};
  assign o_arlen                = 8'(BEATS - 1);
  assign o_rready               = r_rready;
  assign o_awvalid              = r_awvalid;
  assign o_awaddr               = {r_waddr, {OFS_WD{1'b0}}};
  assign o_awlen                = 8'(BEATS - 1);
  assign o_wvalid               = r_wvalid;
  assign o_wdata                = r_wb_line[31:0];
  assign o_wlast                = r_wlast;
  assign o_bready               = r_bready;
  assign o_state                = r_state;

  // Line-offset address bits never reach the bus.
  assign w_unused = &{1'b0, i_icache_raddr[OFS_WD-1:0], i_dcache_raddr[OFS_WD-1:0],
                      i_dcache_waddr[OFS_WD-1:0]};

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: bus slave model, transaction-level scoreboard checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_cache_refill_arbiter;
  localparam int LW    = 512;
  localparam int BEATS = 16;

  logic          clk;
  logic          rst_n;
  logic          icache_miss;
  logic [31:0]   icache_raddr;
  logic          icache_refresh;
  logic [LW-1:0] icache_line;
  logic          dcache_miss;
  logic [31:0]   dcache_raddr;
  logic          dcache_wb;
  logic [31:0]   dcache_waddr;
  logic [LW-1:0] dcache_old;
  logic          dcache_refresh;
  logic [LW-1:0] dcache_line;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [31:0]   araddr, rdata, awaddr, wdata;
  logic [7:0]    arlen, awlen;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [2:0]    state;

  cache_refill_arbiter #(.CACHELINE_WD(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_icache_miss(icache_miss), .i_icache_raddr(icache_raddr),
    .o_icache_refresh(icache_refresh), .o_icache_cacheline_new(icache_line),
    .i_dcache_miss(dcache_miss), .i_dcache_raddr(dcache_raddr),
    .i_dcache_write_back(dcache_wb), .i_dcache_waddr(dcache_waddr),
    .i_dcache_cacheline_old(dcache_old),
    .o_dcache_refresh(dcache_refresh), .o_dcache_cacheline_new(dcache_line),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arlen(arlen),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rlast(rlast),
    .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awlen(awlen),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wlast(wlast),
    .i_bvalid(bvalid), .o_bready(bready), .o_state(state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit          is_d;
    bit          wb;
    logic [31:0] awaddr;
    logic [31:0] araddr;
    int          rbeats;
  } txn_t;

  txn_t          txn_q[$];
  logic [31:0]   exp_q[$];
  logic [LW-1:0] m_line = '0;
  int            m_beat = 0;
  bit            aw_done, b_done, ar_done, rd_done;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            rf_count = 0;
  int            last_rf_cyc = 0;
  bit            last_rf_is_d;
  int            ar_rise_cyc = 0;
  logic [31:0]   ar_seen_addr = '0;
  logic [31:0]   aw_seen_addr = '0;
  logic [31:0]   w_last_word = '0;
  int            w_beats_seen = 0;
  bit            prev_arvalid, prev_rf;

  // next-edge handshake flags, sampled mid-cycle, consumed by the slave after the edge
  bit nx_aw, nx_w, nx_wlast, nx_b, nx_ar, nx_r, nx_rlast;

  // ---------------- slave configuration ----------------
  int          cfg_ar_delay = 0;
  bit          cfg_rgap = 0;
  int          cfg_w_stall_beat = -1;
  int          cfg_rlast_beat = BEATS - 1;
  logic [31:0] mem [BEATS];

  int ar_cnt, r_beat, w_beat, stall_cnt;
  bit r_active;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- slave driver ----------------
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0;
    ar_cnt = 0; r_beat = 0; w_beat = 0; stall_cnt = 0; r_active = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        arready = 0; rvalid = 0; rlast = 0; rdata = 0;
        awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; r_beat = 0; w_beat = 0; stall_cnt = 0; r_active = 0;
      end else begin
        awready = 1;
        if (nx_aw) begin
          w_beat = 0;
          stall_cnt = 0;
        end
        if (nx_b) bvalid = 0;
        if (nx_w) begin
          w_beat++;
          stall_cnt = 0;
          if (nx_wlast) bvalid = 1;
        end else if (wvalid && w_beat == cfg_w_stall_beat) begin
          stall_cnt++;
        end
        wready = !(w_beat == cfg_w_stall_beat && stall_cnt < 3);
        if (nx_ar) begin
          ar_cnt = 0;
          r_active = 1;
          r_beat = 0;
        end else if (arvalid) begin
          ar_cnt++;
        end
        arready = (ar_cnt >= cfg_ar_delay);
        if (nx_r) begin
          if (nx_rlast) r_active = 0;
          r_beat++;
        end
        if (!r_active) begin
          rvalid = 0;
          rlast = 0;
        end else if (!(rvalid && !nx_r)) begin
          if (cfg_rgap && $urandom_range(0, 2) == 0) begin
            rvalid = 0;
            rlast = 0;
          end else begin
            rvalid = 1;
            rdata = mem[r_beat];
            rlast = (r_beat == cfg_rlast_beat);
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_aw, exp_w, exp_ar;
    if (!rst_n) begin
      {nx_aw, nx_w, nx_wlast, nx_b, nx_ar, nx_r, nx_rlast} = '0;
      txn_q.delete();
      exp_q.delete();
      m_line = '0;
      m_beat = 0;
      {aw_done, b_done, ar_done, rd_done, prev_arvalid, prev_rf} = '0;
    end else begin
      nx_aw = awvalid && awready;
      nx_w = wvalid && wready;
      nx_wlast = wlast;
      nx_b = bvalid && bready;
      nx_ar = arvalid && arready;
      nx_r = rvalid && rready;
      nx_rlast = rlast;

      if (awvalid) begin
        exp_aw = txn_q.size() > 0 && txn_q[0].wb && !aw_done;
        chk("awvalid_expected", awvalid, exp_aw);
        if (exp_aw) begin
          chk("awaddr", awaddr, txn_q[0].awaddr);
          chk("awlen", awlen, BEATS - 1);
        end
        if (nx_aw) begin
          aw_done = 1;
          aw_seen_addr = awaddr;
          w_beats_seen = 0;
        end
      end
      if (wvalid) begin
        exp_w = aw_done && exp_q.size() > 0;
        chk("wvalid_expected", wvalid, exp_w);
        if (exp_w) begin
          chk("wdata", wdata, exp_q[0]);
          chk("wlast", wlast, exp_q.size() == 1);
          if (nx_w) begin
            w_last_word = wdata;
            w_beats_seen++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (bready) chk("bready_expected", bready, aw_done && exp_q.size() == 0 && !b_done);
      if (nx_b) b_done = 1;
      if (arvalid) begin
        exp_ar = txn_q.size() > 0 && !ar_done && (!txn_q[0].wb || b_done);
        chk("arvalid_expected", arvalid, exp_ar);
        if (exp_ar) begin
          chk("araddr", araddr, txn_q[0].araddr);
          chk("arlen", arlen, BEATS - 1);
        end
        if (!prev_arvalid) ar_rise_cyc = cyc;
        if (nx_ar) begin
          ar_done = 1;
          ar_seen_addr = araddr;
          m_beat = 0;
        end
      end
      if (rready) chk("rready_expected", rready, ar_done && !rd_done);
      if (nx_r && ar_done && !rd_done) begin
        m_line[m_beat*32 +: 32] = rdata;
        m_beat++;
        if (rlast || m_beat == BEATS) rd_done = 1;
      end
      if (icache_refresh || dcache_refresh) begin
        chk("refresh_single_cycle", prev_rf, 1'b0);
        if (txn_q.size() > 0 && rd_done) begin
          chk("refresh_target", {icache_refresh, dcache_refresh},
              txn_q[0].is_d ? 2'b01 : 2'b10);
          chk("icache_line", icache_line, m_line);
          chk("dcache_line", dcache_line, m_line);
          chk("read_beats", m_beat, txn_q[0].rbeats);
          void'(txn_q.pop_front());
        end else begin
          chk("refresh_unexpected", {icache_refresh, dcache_refresh}, 2'b00);
        end
        rf_count++;
        last_rf_cyc = cyc;
        last_rf_is_d = dcache_refresh;
        {aw_done, b_done, ar_done, rd_done} = '0;
      end
      prev_arvalid = arvalid;
      prev_rf = icache_refresh || dcache_refresh;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic set_mem(input logic [31:0] base);
    for (int k = 0; k < BEATS; k++) mem[k] = base + 32'(k);
  endtask

  // Queues the expected transactions (dcache first), raises the misses and
  // returns t0 = cycle count just after the edge that samples them.
  task automatic issue(input bit do_i, input logic [31:0] ia, input bit do_d, input bit wb,
                       input logic [31:0] dra, input logic [31:0] dwa,
                       input logic [LW-1:0] old, input int rbeats, output int t0);
    txn_t t;
    if (do_d) begin
      t.is_d = 1; t.wb = wb; t.awaddr = dwa & 32'hFFFF_FFC0;
      t.araddr = dra & 32'hFFFF_FFC0; t.rbeats = rbeats;
      txn_q.push_back(t);
      if (wb) for (int k = 0; k < BEATS; k++) exp_q.push_back(old[k*32 +: 32]);
    end
    if (do_i) begin
      t.is_d = 0; t.wb = 0; t.awaddr = 0; t.araddr = ia & 32'hFFFF_FFC0; t.rbeats = rbeats;
      txn_q.push_back(t);
    end
    @(posedge clk);
    #1;
    icache_miss = do_i; icache_raddr = ia;
    dcache_miss = do_d; dcache_wb = wb; dcache_raddr = dra; dcache_waddr = dwa; dcache_old = old;
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic wait_rf(input int maxc, input string nm);
    int start;
    start = rf_count;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      #1;
      if (rf_count != start) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no refresh within %0d cycles", nm, maxc);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [LW-1:0] old;
    int t0, d_rf, rise0;
    rst_n = 0;
    icache_miss = 0; icache_raddr = 0;
    dcache_miss = 0; dcache_wb = 0; dcache_raddr = 0; dcache_waddr = 0; dcache_old = '0;
    set_mem(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state_idle", state, 3'd0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_refresh", {icache_refresh, dcache_refresh}, 0);
    chk("rst_line", icache_line, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    // Plain icache refill, zero-wait slave; the miss cycle counts as cycle 1.
    set_mem(0);
    issue(1, 32'h1C00_0104, 0, 0, 0, 0, '0, BEATS, t0);
    wait_rf(100, "t1_refresh");
    icache_miss = 0;
    chk("t1_latency", last_rf_cyc - t0 + 2, 19);
    chk("t1_araddr_lit", ar_seen_addr, 32'h1C00_0100);
    chk("t1_is_icache", last_rf_is_d, 0);
    chk("t1_word0", icache_line[31:0], 32'd0);
    chk("t1_word15", icache_line[511:480], 32'd15);
    repeat (3) @(posedge clk);

    // dcache miss with write-back of a dirty victim.
    for (int k = 0; k < BEATS; k++) old[k*32 +: 32] = 32'hA0 + 32'(k);
    set_mem(32'h100);
    issue(0, 0, 1, 1, 32'h0000_3000, 32'h0000_2040, old, BEATS, t0);
    wait_rf(200, "t2_refresh");
    dcache_miss = 0;
    chk("t2_latency", last_rf_cyc - t0 + 2, 37);
    chk("t2_awaddr_lit", aw_seen_addr, 32'h0000_2040);
    chk("t2_w_beats", w_beats_seen, 16);
    chk("t2_last_wdata", w_last_word, 32'hAF);
    chk("t2_is_dcache", last_rf_is_d, 1);
    chk("t2_word5", dcache_line[191:160], 32'h105);
    repeat (3) @(posedge clk);

    // Simultaneous misses: dcache first, icache AR three cycles after its refresh.
    set_mem(32'h200);
    issue(1, 32'h0000_5000, 1, 0, 32'h0000_6000, 0, '0, BEATS, t0);
    wait_rf(200, "t3_d_refresh");
    dcache_miss = 0;
    chk("t3_first_is_dcache", last_rf_is_d, 1);
    d_rf = last_rf_cyc;
    rise0 = ar_rise_cyc;
    for (int k = 0; k < 20 && ar_rise_cyc == rise0; k++) @(posedge clk);
    #1;
    chk("t3_icache_ar_gap", ar_rise_cyc - d_rf, 3);
    wait_rf(200, "t3_i_refresh");
    icache_miss = 0;
    chk("t3_second_is_icache", last_rf_is_d, 0);
    repeat (3) @(posedge clk);

    // Stalls: slow arready, random read gaps, wready low on write beat 7.
    cfg_ar_delay = 5; cfg_rgap = 1; cfg_w_stall_beat = 7;
    for (int k = 0; k < BEATS; k++) old[k*32 +: 32] = 32'hB0 + 32'(k);
    set_mem(32'h4000_0000);
    issue(0, 0, 1, 1, 32'h0000_7040, 32'h0000_8000, old, BEATS, t0);
    wait_rf(600, "t4_refresh");
    dcache_miss = 0;
    chk("t4_w_beats", w_beats_seen, 16);
    chk("t4_stalled_longer", last_rf_cyc - t0 + 2 > 37, 1);
    chk("t4_word9", dcache_line[319:288], 32'h4000_0009);
    cfg_ar_delay = 0; cfg_rgap = 0; cfg_w_stall_beat = -1;
    repeat (3) @(posedge clk);

    // Early rlast on beat 3: words 4..15 keep the previous line.
    cfg_rlast_beat = 3;
    set_mem(32'h500);
    issue(1, 32'h0000_9000, 0, 0, 0, 0, '0, 4, t0);
    wait_rf(100, "t5_refresh");
    icache_miss = 0;
    chk("t5_word3", icache_line[127:96], 32'h503);
    chk("t5_word4_kept", icache_line[159:128], 32'h4000_0004);
    chk("t5_word15_kept", icache_line[511:480], 32'h4000_000F);
    cfg_rlast_beat = BEATS - 1;
    repeat (3) @(posedge clk);

    // Reset in the middle of the read burst, then a fresh refill.
    set_mem(32'h600);
    issue(1, 32'h0000_A000, 0, 0, 0, 0, '0, BEATS, t0);
    for (int k = 0; k < 40 && m_beat < 8; k++) begin
      @(negedge clk);
      #1;
    end
    chk("t6_reached_beat8", m_beat >= 8, 1);
    d_rf = rf_count;
    #1;
    rst_n = 0;
    #1;
    chk("t6_async_state", state, 3'd0);
    chk("t6_async_rready", rready, 0);
    chk("t6_async_arvalid", arvalid, 0);
    chk("t6_async_araddr", araddr, 0);
    chk("t6_async_line", icache_line, 0);
    icache_miss = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_refresh", rf_count, d_rf);
    rst_n = 1;
    repeat (2) @(posedge clk);
    set_mem(32'h700);
    issue(1, 32'h0000_B000, 0, 0, 0, 0, '0, BEATS, t0);
    wait_rf(100, "t6_refresh");
    icache_miss = 0;
    chk("t6_word0", icache_line[31:0], 32'h700);
    chk("t6_word15", icache_line[511:480], 32'h70F);
    repeat (3) @(posedge clk);

    // One-cycle miss pulse is still served to completion.
    set_mem(32'h800);
    issue(1, 32'h0000_C000, 0, 0, 0, 0, '0, BEATS, t0);
    icache_miss = 0;
    wait_rf(100, "t7_refresh");
    chk("t7_word2", icache_line[95:64], 32'h802);
    repeat (4) @(posedge clk);
    #1;
    chk("end_txn_queue_empty", txn_q.size(), 0);
    chk("end_state_idle", state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_refill_arbiter.md
CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 The block SHALL have parameter CACHELINE_WD, default 512, cache line width in bits; must be a multiple of 32.
REQ-002 The block SHALL have derived constant BEATS = CACHELINE_WD/32, default 16, with OFS_WD = log2(CACHELINE_WD/8), default 6.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 icache_miss, icache_raddr  in  1, 32  instruction-cache refill request and miss address.
REQ-006 icache_refresh  out  1  one-cycle pulse; icache_cacheline_new is valid in that cycle.
REQ-007 icache_cacheline_new  out  CACHELINE_WD  assembled refill line for the instruction cache.
REQ-008 dcache_miss, dcache_raddr  in  1, 32  data-cache refill request and miss address.
REQ-009 dcache_write_back, dcache_waddr, dcache_cacheline_old  in  1, 32, CACHELINE_WD  dirty victim flag, victim address, victim line; all are sampled with dcache_miss.
REQ-010 dcache_refresh, dcache_cacheline_new  out  1, CACHELINE_WD  same semantics as the icache pair.
REQ-011 arvalid/arready, araddr[31:0], arlen[7:0]  out/in/out/out  read address channel.
REQ-012 rvalid/rready, rdata[31:0], rlast  in/out/in/in  read data channel.
REQ-013 awvalid/awready, awaddr[31:0], awlen[7:0]  out/in/out/out  write address channel.
REQ-014 wvalid/wready, wdata[31:0], wlast  out/in/out/out  write data channel; all byte strobes are implied set.
REQ-015 bvalid/bready  in/out  write response channel.

Function
REQ-016 The FSM SHALL have the states IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFRESH, COOL.
REQ-017 In IDLE, dcache_miss SHALL have priority over icache_miss; grant is registered, one requester per transaction, with no preemption.
REQ-018 On grant, the block SHALL latch the address, requester id, and (for dcache) write_back, waddr and cacheline_old; inputs are ignored until the next IDLE.
REQ-019 A dcache grant with write_back=1 SHALL go to WB_AW; otherwise the grant goes to RD_AR.
REQ-020 WB_AW: awvalid=1, awaddr={waddr[31:OFS_WD], 0}, awlen=BEATS-1; on the awready handshake, go to WB_W.
REQ-021 WB_W: beat i SHALL drive wdata=line[32i+31:32i], starting at i=0; wlast=1 only on beat BEATS-1; the beat counter advances only on wvalid&&wready; after the last beat, go to WB_B.
REQ-022 WB_B: bready=1; on bvalid, go to RD_AR.
REQ-023 The write-back SHALL complete before the refill read is issued.
REQ-024 RD_AR: arvalid=1, araddr={raddr[31:OFS_WD], 0}, arlen=BEATS-1; on arready, go to RD_R.
REQ-025 RD_R: rready=1; each rvalid beat i SHALL be stored to buffer bits [32i+31:32i].
REQ-026 RD_R SHALL leave on the beat where rlast=1 or i=BEATS-1, whichever comes first, and go to REFRESH.
REQ-027 REFRESH: the granted requester's refresh SHALL be 1 for exactly one cycle; both cacheline_new outputs present the buffer; then go to COOL.
REQ-028 COOL: one cycle with no grant, so the cache can drop its miss; then go to IDLE.
REQ-029 The valid outputs (awvalid, wvalid, arvalid) SHALL be held until their handshake completes, with payload stable; the ready outputs (bready, rready) SHALL be 0 outside their states.
REQ-030 Minimum latency, from miss seen in IDLE to refresh with zero-wait slave: no write-back = 1+1+BEATS+1 cycles; with write-back, add BEATS+2.
REQ-031 Simultaneous misses: dcache is served first; icache is granted at the first IDLE after COOL if still asserted.
REQ-032 A miss that deasserts while the FSM is busy SHALL NOT abort the transaction; refresh is still pulsed.

Reset
REQ-033 While reset=0, the FSM SHALL be in IDLE, all valid/ready/refresh outputs 0, beat counter 0, and the line buffer and latched addresses 0.
REQ-034 Reset assertion mid-burst SHALL abandon the transaction immediately, with no refresh; after release, the FSM starts fresh in IDLE.

Verification
REQ-035 icache_miss, raddr=0x1C00_0104, zero-wait slave returning words 0..15 -> araddr=0x1C00_0100, arlen=15; icache_refresh one pulse at cycle 19; line[31:0]=0, line[511:480]=15.
REQ-036 dcache_miss with write_back=1, waddr=0x0000_2040, old line word i = 0xA0+i -> AW addr 0x0000_2040; 16 W beats 0xA0..0xAF with wlast on the 16th; B accepted before arvalid rises; dcache_refresh only, icache_refresh stays 0.
REQ-037 icache_miss and dcache_miss asserted in the same cycle -> dcache read is issued first; icache araddr is issued only after dcache_refresh plus one COOL cycle.
REQ-038 Stalls: arready delayed 5 cycles, random rvalid gaps, wready low on beat 7 -> araddr and wdata stay stable; no beat is lost or duplicated; the line is correct.
REQ-039 reset driven low during RD_R beat 8 -> all outputs are 0 asynchronously; no refresh; a new icache_miss after release completes normally.
REQ-040 rlast asserted early on beat 3 -> the FSM goes to REFRESH; the remaining words of the line hold their previous values.
